// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, sync polarity and the output-stage record
// used by the display driver and its counter.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int H_FP_DEFAULT     = 16;
    localparam int H_SYNC_DEFAULT   = 96;
    localparam int H_BP_DEFAULT     = 48;
    localparam int H_TOTAL_DEFAULT  = H_ACTIVE_DEFAULT + H_FP_DEFAULT
                                    + H_SYNC_DEFAULT + H_BP_DEFAULT;

    localparam int V_ACTIVE_DEFAULT = 480;
    localparam int V_FP_DEFAULT     = 10;
    localparam int V_SYNC_DEFAULT   = 2;
    localparam int V_BP_DEFAULT     = 33;
    localparam int V_TOTAL_DEFAULT  = V_ACTIVE_DEFAULT + V_FP_DEFAULT
                                    + V_SYNC_DEFAULT + V_BP_DEFAULT;

    // Level driven on the sync pins during the sync pulse (pins are active-low).
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } vga_out_t;

    localparam vga_out_t OUT_IDLE = '{r: 4'h0, g: 4'h0, b: 4'h0,
                                      hs: ~SYNC_ACTIVE, vs: ~SYNC_ACTIVE};

    // True when cnt lies in the inclusive window [lo, hi].
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input int lo, input int hi);
        return (int'(cnt) >= lo) && (int'(cnt) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider plus horizontal/vertical raster counters.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = H_TOTAL_DEFAULT,
    parameter int V_TOTAL = V_TOTAL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pix_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             frame_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div;
    logic             line_end;

    assign pix_en    = (div == DIV_LAST);
    assign line_end  = pix_en && (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);

    // Divider: counts 0..CLK_DIV-1 and restarts on every pixel enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Raster position: hcnt advances per pixel slot, vcnt per completed line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_display_driver.sv
// VGA display driver: requests pixels by coordinate from the colour source
// and drives registered RGB and active-low sync pins one pixel slot later.
module vga_display_driver
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int H_FP     = H_FP_DEFAULT,
    parameter int H_SYNC   = H_SYNC_DEFAULT,
    parameter int H_BP     = H_BP_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int V_FP     = V_FP_DEFAULT,
    parameter int V_SYNC   = V_SYNC_DEFAULT,
    parameter int V_BP     = V_BP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      pix_color,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_req,
    output logic             frame_start,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    logic             pix_en;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             frame_end;
    logic             active;
    vga_out_t         out_p0;
    vga_out_t         out_p1;

    vga_sync_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_sync_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .frame_end (frame_end)
    );

    assign active      = (hcnt < CNT_W'(H_ACTIVE)) && (vcnt < CNT_W'(V_ACTIVE));
    assign pix_x       = hcnt;
    assign pix_y       = vcnt;
    // Requests are withheld while reset is held so the source sees no fetch
    // for the abandoned frame.
    assign pix_req     = rst_n && active;
    assign frame_start = frame_end;

    // Stage p0: colour/blanking and sync levels for the slot now being requested.
    always_comb begin
        out_p0    = OUT_IDLE;
        out_p0.r  = active ? pix_color[11:8] : 4'h0;
        out_p0.g  = active ? pix_color[7:4]  : 4'h0;
        out_p0.b  = active ? pix_color[3:0]  : 4'h0;
        out_p0.hs = in_window(hcnt, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        out_p0.vs = in_window(vcnt, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Stage p1: pin register, loaded once per pixel slot so RGB and syncs stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= OUT_IDLE;
        end else if (pix_en) begin
            out_p1 <= out_p0;
        end
    end

    assign vga_r  = out_p1.r;
    assign vga_g  = out_p1.g;
    assign vga_b  = out_p1.b;
    assign vga_hs = out_p1.hs;
    assign vga_vs = out_p1.vs;

endmodule

// File: tb/tb_vga_display_driver.sv
// Self-checking bench for vga_display_driver, run with a shrunken raster so
// whole frames fit in a short simulation.
module tb_vga_display_driver;

    localparam int CLK_DIV  = 4;
    localparam int H_ACTIVE = 20;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 6;
    localparam int H_BP     = 6;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int LINE     = H_TOTAL * CLK_DIV;
    localparam int FRAME    = LINE * V_TOTAL;
    localparam int HS_FALL  = (H_ACTIVE + H_FP + 1) * CLK_DIV;
    localparam int VS_FALL  = ((V_ACTIVE + V_FP) * H_TOTAL + 1) * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] pix_color;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_req;
    logic        frame_start;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int m_div, m_h, m_v;
    logic [13:0] sbq[$];

    vga_display_driver #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_color   (pix_color),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_req     (pix_req),
        .frame_start (frame_start),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference raster position derived from clocks elapsed since reset release.
    task automatic update_model();
        int slot;
        m_div = t % CLK_DIV;
        slot  = t / CLK_DIV;
        m_h   = slot % H_TOTAL;
        m_v   = (slot / H_TOTAL) % V_TOTAL;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) t++;
        @(negedge clk);
        update_model();
    endtask

    // Expected {r,g,b,hs,vs} for a slot at (h,v) given the colour the source returned.
    function automatic logic [13:0] exp_out(input int h, input int v, input logic [11:0] c);
        logic act, hs, vs;
        act = (h < H_ACTIVE) && (v < V_ACTIVE);
        hs  = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
        vs  = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
        return {act ? c : 12'h000, hs, vs};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        pix_color = 12'hFFF;
        repeat (10) tick();
        total++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            bad++; $display("FAIL reset_rgb: got %h want 000", {vga_r, vga_g, vga_b});
        end
        total++;
        if ({vga_hs, vga_vs} !== 2'b11) begin
            bad++; $display("FAIL reset_sync: got %b want 11", {vga_hs, vga_vs});
        end
        total++;
        if ({pix_x, pix_y} !== 20'd0) begin
            bad++; $display("FAIL reset_xy: got %0d,%0d want 0,0", pix_x, pix_y);
        end
        total++;
        if ({pix_req, frame_start} !== 2'b00) begin
            bad++; $display("FAIL reset_req_fs: got %b want 00", {pix_req, frame_start});
        end
        rst_n = 1'b1;
        t = 0;
        update_model();
        #1;
        total++;
        if (pix_req !== 1'b1) begin
            bad++; $display("FAIL release_req: got %b want 1", pix_req);
        end
    endtask

    task automatic test_hsync();
        int   falls  = 0;
        int   t_fall = 0;
        logic prev_hs;
        prev_hs = vga_hs;
        for (int i = 0; i < 3 * LINE && falls < 2; i++) begin
            tick();
            if (prev_hs === 1'b1 && vga_hs === 1'b0) begin
                total++;
                if (falls == 0) begin
                    if ((t % LINE) != HS_FALL) begin
                        bad++; $display("FAIL hs_phase: got %0d want %0d", t % LINE, HS_FALL);
                    end
                end else if (t - t_fall != LINE) begin
                    bad++; $display("FAIL hs_period: got %0d want %0d", t - t_fall, LINE);
                end
                t_fall = t;
                falls++;
            end else if (prev_hs === 1'b0 && vga_hs === 1'b1 && falls > 0) begin
                total++;
                if (t - t_fall != H_SYNC * CLK_DIV) begin
                    bad++; $display("FAIL hs_width: got %0d want %0d", t - t_fall, H_SYNC * CLK_DIV);
                end
            end
            prev_hs = vga_hs;
        end
        total++;
        if (falls != 2) begin
            bad++; $display("FAIL hs_edges: got %0d want 2", falls);
        end
    endtask

    task automatic test_color();
        logic [13:0] exp, got;
        logic [11:0] mc;
        sbq.delete();
        for (int i = 0; i < FRAME + 4 * CLK_DIV && !(i >= FRAME && sbq.size() == 0); i++) begin
            tick();
            if (m_div == 0 && sbq.size() > 0) begin
                exp = sbq.pop_front();
                got = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
                total++;
                if (got !== exp) begin
                    bad++; $display("FAIL color_px t=%0d: got %h want %h", t, got, exp);
                end
            end
            pix_color = pix_req ? 12'hF0A : 12'hFFF;
            mc = ((m_h < H_ACTIVE) && (m_v < V_ACTIVE)) ? 12'hF0A : 12'hFFF;
            if (i < FRAME && m_div == CLK_DIV - 1) sbq.push_back(exp_out(m_h, m_v, mc));
        end
        total++;
        if (sbq.size() != 0) begin
            bad++; $display("FAIL color_drain: got %0d left want 0", sbq.size());
        end
    endtask

    task automatic test_frame();
        int   seen = 0, expect_n = 0, t_last = -1, t_vfall = -1;
        logic prev_vs, exp_fs;
        prev_vs = vga_vs;
        for (int i = 0; i < 2 * FRAME + 200; i++) begin
            tick();
            exp_fs = (m_div == CLK_DIV - 1) && (m_h == H_TOTAL - 1) && (m_v == V_TOTAL - 1);
            if (exp_fs) expect_n++;
            if (frame_start === 1'b1) begin
                seen++;
                if (t_last >= 0) begin
                    total++;
                    if (t - t_last != FRAME) begin
                        bad++; $display("FAIL fs_period: got %0d want %0d", t - t_last, FRAME);
                    end
                end
                t_last = t;
            end
            if (frame_start === 1'b1 || exp_fs) begin
                total++;
                if (frame_start !== exp_fs) begin
                    bad++; $display("FAIL fs_pulse t=%0d: got %b want %b", t, frame_start, exp_fs);
                end
            end
            if (prev_vs === 1'b1 && vga_vs === 1'b0) begin
                total++;
                if ((t % FRAME) != VS_FALL) begin
                    bad++; $display("FAIL vs_phase: got %0d want %0d", t % FRAME, VS_FALL);
                end
                t_vfall = t;
            end else if (prev_vs === 1'b0 && vga_vs === 1'b1 && t_vfall >= 0) begin
                total++;
                if (t - t_vfall != V_SYNC * LINE) begin
                    bad++; $display("FAIL vs_width: got %0d want %0d", t - t_vfall, V_SYNC * LINE);
                end
            end
            prev_vs = vga_vs;
        end
        total++;
        if (seen != expect_n || seen < 2) begin
            bad++; $display("FAIL fs_count: got %0d want %0d", seen, expect_n);
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        pix_color = 12'h5A5;
        while (!(m_h == 10 && m_v == 5) && guard < FRAME + 10) begin
            tick();
            guard++;
        end
        total++;
        if (guard >= FRAME + 10) begin
            bad++; $display("FAIL mr_reach: got timeout want h=10 v=5");
            return;
        end
        total++;
        if ({vga_r, vga_g, vga_b} !== 12'h5A5) begin
            bad++; $display("FAIL mr_pre_rgb: got %h want 5a5", {vga_r, vga_g, vga_b});
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {12'h000, 2'b11}) begin
            bad++; $display("FAIL mr_async_idle: got %h want 0003", {vga_r, vga_g, vga_b, vga_hs, vga_vs});
        end
        total++;
        if ({pix_x, pix_y, pix_req, frame_start} !== 22'd0) begin
            bad++; $display("FAIL mr_async_ctr: got x=%0d y=%0d req=%b", pix_x, pix_y, pix_req);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        t = 0;
        update_model();
        for (int i = 0; i < 13; i++) begin
            total++;
            if (pix_x !== 10'(t / CLK_DIV) || pix_y !== 10'd0) begin
                bad++; $display("FAIL mr_resume t=%0d: got %0d,%0d want %0d,0", t, pix_x, pix_y, t / CLK_DIV);
            end
            if (t == CLK_DIV - 1) begin
                total++;
                if ({vga_r, vga_g, vga_b} !== 12'h000) begin
                    bad++; $display("FAIL mr_pre_first_slot: got %h want 000", {vga_r, vga_g, vga_b});
                end
            end
            tick();
        end
    endtask

    task automatic test_alignment();
        logic [13:0] exp, got;
        logic [3:0]  hv;
        sbq.delete();
        for (int i = 0; i < 3 * LINE + 4 * CLK_DIV && !(i >= 3 * LINE && sbq.size() == 0); i++) begin
            tick();
            if (m_div == 0 && sbq.size() > 0) begin
                exp = sbq.pop_front();
                got = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
                total++;
                if (got !== exp) begin
                    bad++; $display("FAIL align_px t=%0d: got %h want %h", t, got, exp);
                end
            end
            pix_color = {pix_x[3:0], pix_x[3:0], pix_x[3:0]};
            hv = 4'(m_h);
            if (i < 3 * LINE && m_div == CLK_DIV - 1) sbq.push_back(exp_out(m_h, m_v, {hv, hv, hv}));
        end
        total++;
        if (sbq.size() != 0) begin
            bad++; $display("FAIL align_drain: got %0d left want 0", sbq.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        pix_color = 12'h000;
        test_reset();
        test_hsync();
        test_color();
        test_frame();
        test_mid_reset();
        test_alignment();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_display_driver.md
VGA_DISPLAY_DRIVER -- requirements
Module: vga_display_driver

Interface
REQ-001 Parameters (name, default, meaning): CLK_DIV, 4, system clocks per pixel; H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal pixel counts; V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical line counts.
REQ-002 clk  in  1  system clock (100 MHz), sole clock; all state on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 pix_color  in  12  {R[3:0],G[3:0],B[3:0]} from the title/camera select stage, returned for the last requested pixel.
REQ-005 pix_x  out  10  horizontal pixel coordinate being requested.
REQ-006 pix_y  out  10  vertical line coordinate being requested.
REQ-007 pix_req  out  1  high while (pix_x,pix_y) lies in the active area.
REQ-008 frame_start  out  1  one-clk pulse at the start of each frame (h=0,v=0).
REQ-009 vga_r, vga_g, vga_b  out  4 each  pin-level colour.
REQ-010 vga_hs, vga_vs  out  1 each  sync pins, active-low.

Function
REQ-011 Pixel enable pix_en shall pulse one clk every CLK_DIV clks from a divider counter 0..CLK_DIV-1; pix_en is high when divider = CLK_DIV-1.
REQ-012 hcnt shall count 0..H_TOTAL-1 (800) on pix_en, wrapping to 0; at the wrap, vcnt shall increment, wrapping 524->0.
REQ-013 pix_x=hcnt, pix_y=vcnt; pix_req=(hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE); combinational from registered counters.
REQ-014 Source latency budget: pix_color shall be valid within CLK_DIV-1 clks after pix_x/pix_y change; driver samples it only on pix_en.
REQ-015 On pix_en, output stage shall register: RGB=pix_color if pix_req else 12'h000; hs=~(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) i.e. 656..751; vs=~(vcnt in 490..491).
REQ-016 Output latency: RGB/hs/vs lag counters by exactly one pixel slot; all three aligned to each other.
REQ-017 Blanking: RGB shall be 0 whenever the registered pixel is outside the active area, regardless of pix_color.
REQ-018 frame_start shall be high for the single clk in which pix_en is high and hcnt=H_TOTAL-1, vcnt=V_TOTAL-1 (counters become 0,0 next clk).
REQ-019 Line period = 800*CLK_DIV clks (3200); frame period = 525 lines (1,680,000 clks).
REQ-020 Widths: H_TOTAL and V_TOTAL shall fit in 10 bits; counters shall never exceed TOTAL-1.

Reset
REQ-021 While rst_n=0: divider, hcnt, vcnt = 0; vga_hs=vga_vs=1; RGB=0; frame_start=0; outputs change asynchronously on rst_n fall.
REQ-022 Reset mid-frame shall abandon the frame; after release, first pix_en occurs CLK_DIV clks later and timing restarts from h=0,v=0 with no frame_start until the next full wrap.

Structure
REQ-023 Shared package vga_timing_pkg shall hold the H_/V_ timing constants, H_TOTAL/V_TOTAL, and sync polarity.
REQ-024 One sub-module vga_sync_counter (divider + hcnt/vcnt + pix_en); output register stage in the top.

Verification
REQ-025 Reset: hold rst_n=0 for 10 clks -> hs=vs=1, RGB=0, pix_x=pix_y=0, pix_req=0 (pix_req reflects (0,0) active only after release: =1).
REQ-026 Hsync: run one line -> vga_hs low for exactly 384 clks, falling 657*4 clks after line start (counter slot 656 + 1-slot lag); period 3200 clks.
REQ-027 Vsync/frame: run 1.7M clks -> vga_vs low for 2 lines (6400 clks); frame_start pulses exactly once per 1,680,000 clks.
REQ-028 Colour: pix_color=12'hF0A while pix_req=1 -> vga_r=F,vga_g=0,vga_b=A one slot later; pix_color=12'hFFF at hcnt=700 -> RGB=0.
REQ-029 Mid-line reset: assert rst_n=0 at hcnt=300,vcnt=100 for 3 clks -> outputs idle immediately; after release pix_x resumes 0,1,2 every 4 clks, pix_y=0.
REQ-030 Alignment: pix_color tied to {hcnt[3:0],hcnt[3:0],hcnt[3:0]} -> each output pixel value equals its slot index mod 16, no skipped/duplicated pixels across line wrap.
